// File: rtl/sat_pkg.sv
// ---------------------------------------------------------------------------
// sat_pkg
// Shared definitions for the SAT clause sequencer:
//   - stateVal phase codes driven to the accelerator top
//   - clause record layout {neg2, var2, neg1, var1} as offset helpers
//   - sequencer FSM state enum and the state -> stateVal mapping
// ---------------------------------------------------------------------------
package sat_pkg;

    // Phase codes on stateVal
    localparam logic [1:0] SV_RST_ALL    = 2'b00;  // reset clause and CNF
    localparam logic [1:0] SV_RST_CLAUSE = 2'b01;  // reset clause only (idle/hold)
    localparam logic [1:0] SV_CLAUSE_EN  = 2'b10;  // clause evaluate
    localparam logic [1:0] SV_CNF_EN     = 2'b11;  // CNF accumulate

    // Clause record layout, LSB first: var1, neg1, var2, neg2.
    localparam int VAR1_LSB = 0;

    function automatic int neg1_bit(input int var_w);
        return var_w;
    endfunction

    function automatic int var2_lsb(input int var_w);
        return var_w + 1;
    endfunction

    function automatic int neg2_bit(input int var_w);
        return 2 * var_w + 1;
    endfunction

    function automatic int rec_w(input int var_w);
        return 2 * var_w + 2;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_CLR,
        ST_EVAL,
        ST_ACC,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    // Phase code presented while the FSM sits in a given state.
    function automatic logic [1:0] state_code(input seq_state_e s);
        logic [1:0] code;
        case (s)
            ST_RST:  code = SV_RST_ALL;
            ST_EVAL: code = SV_CLAUSE_EN;
            ST_ACC:  code = SV_CNF_EN;
            default: code = SV_RST_CLAUSE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sat_clause_rf.sv
// ---------------------------------------------------------------------------
// sat_clause_rf
// Clause register file: one synchronous write port, one asynchronous read
// port. Contents are not cleared by reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe (already qualified by the caller)
//   wr_addr  in   slot to write
//   wr_data  in   clause record {neg2, var2, neg1, var1}
//   rd_addr  in   slot to read
//   rd_data  out  clause record at rd_addr (combinational)
// ---------------------------------------------------------------------------
module sat_clause_rf #(
    parameter int DEPTH = 16,
    parameter int REC_W = 12
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [REC_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [REC_W-1:0]         rd_data
);

    logic [REC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sat_clause_sequencer.sv
// ---------------------------------------------------------------------------
// sat_clause_sequencer
// Upstream driver for the SAT accelerator top. Holds a 2-literal CNF formula
// in a register file; on start it streams every clause as the phase triple
// CLR(01) / EVAL(10) / ACC(11), preceded by one RST(00) cycle, waits
// RESULT_LAT cycles, then captures outCNF as the verdict.
//
// Optional feature (macro SEQ_TAUTO_SKIP_EN): tautological clauses
// (var1 == var2, neg1 != neg2) are skipped in a single held-01 cycle without
// issuing EVAL/ACC or loading their fields.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  formula write port (ignored while busy)
//   num_clauses          clause count, latched (and clamped) at start
//   start                run request pulse (ignored while busy)
//   busy, done           run in progress / one-cycle verdict-valid pulse
//   sat_result           captured verdict, held until the next done
//   stateVal             phase code to the accelerator
//   varPos1/2, negCtrl1/2  literal fields of the current clause
//   outCNF               accelerator verdict input
// All outputs are registered.
// ---------------------------------------------------------------------------
module sat_clause_sequencer
    import sat_pkg::*;
#(
    parameter int MAX_CLAUSES = 16,
    parameter int VAR_W       = 5,
    parameter int RESULT_LAT  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(MAX_CLAUSES)-1:0] wr_addr,
    input  logic [2*VAR_W+1:0]             wr_data,
    input  logic [$clog2(MAX_CLAUSES):0]   num_clauses,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           sat_result,
    output logic [1:0]                     stateVal,
    output logic [VAR_W-1:0]               varPos1,
    output logic [VAR_W-1:0]               varPos2,
    output logic                           negCtrl1,
    output logic                           negCtrl2,
    input  logic                           outCNF
);

    localparam int ADDR_W = $clog2(MAX_CLAUSES);
    localparam int REC_W  = rec_w(VAR_W);
    localparam int NEG1_B = neg1_bit(VAR_W);
    localparam int VAR2_L = var2_lsb(VAR_W);
    localparam int NEG2_B = neg2_bit(VAR_W);
    localparam int WAIT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESULT_LAT - 1);
    localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W + 1)'(MAX_CLAUSES);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;

    logic [1:0]        sv_q, sv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sat_q, sat_d;
    logic [VAR_W-1:0]  v1_q, v1_d;
    logic [VAR_W-1:0]  v2_q, v2_d;
    logic              n1_q, n1_d;
    logic              n2_q, n2_d;

`ifdef SEQ_TAUTO_SKIP_EN
    logic              skip_q, skip_d;    // clause shown in the current CLR is a tautology
    logic              issued_q, issued_d; // at least one clause reached ACC this run
`endif

    logic [ADDR_W-1:0] rd_addr;
    logic [REC_W-1:0]  rd_data;
    logic              rf_we;
    logic              is_last;
    logic              force_sat;

    // The formula is frozen once a run is accepted.
    assign rf_we = wr_en && (state_q == ST_IDLE);

    sat_clause_rf #(
        .DEPTH (MAX_CLAUSES),
        .REC_W (REC_W)
    ) u_rf (
        .clk     (clk),
        .wr_en   (rf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign is_last = ({1'b0, idx_q} == (cnt_q - CNT_ONE));

    // An empty run (no clause ever accumulated) is satisfiable by definition.
`ifdef SEQ_TAUTO_SKIP_EN
    assign force_sat = !issued_q;
`else
    assign force_sat = (cnt_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        sat_d   = sat_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
`ifdef SEQ_TAUTO_SKIP_EN
        skip_d   = skip_q;
        issued_d = issued_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = (num_clauses > MAX_CNT) ? MAX_CNT : num_clauses;
                    idx_d   = '0;
                    state_d = ST_RST;
`ifdef SEQ_TAUTO_SKIP_EN
                    issued_d = 1'b0;
`endif
                end
            end
            ST_RST: begin
                if (cnt_q != '0) begin
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_WAIT;
                    wcnt_d  = '0;
                end
            end
            ST_CLR: begin
`ifdef SEQ_TAUTO_SKIP_EN
                if (skip_q) begin
                    if (is_last) begin
                        state_d = ST_WAIT;
                        wcnt_d  = '0;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    state_d = ST_EVAL;
                end
`else
                state_d = ST_EVAL;
`endif
            end
            ST_EVAL: begin
                state_d = ST_ACC;
            end
            ST_ACC: begin
`ifdef SEQ_TAUTO_SKIP_EN
                issued_d = 1'b1;
`endif
                if (is_last) begin
                    state_d = ST_WAIT;
                    wcnt_d  = '0;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_CLR;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                    sat_d   = force_sat ? 1'b1 : outCNF;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clause fields are fetched at the edge that enters CLR, using the
        // index the FSM is about to present, so they are stable through ACC.
        rd_addr = idx_d;
        if (state_d == ST_CLR) begin
`ifdef SEQ_TAUTO_SKIP_EN
            skip_d = (rd_data[VAR1_LSB +: VAR_W] == rd_data[VAR2_L +: VAR_W]) &&
                     (rd_data[NEG1_B] != rd_data[NEG2_B]);
            if (!skip_d) begin
                v1_d = rd_data[VAR1_LSB +: VAR_W];
                v2_d = rd_data[VAR2_L +: VAR_W];
                n1_d = rd_data[NEG1_B];
                n2_d = rd_data[NEG2_B];
            end
`else
            v1_d = rd_data[VAR1_LSB +: VAR_W];
            v2_d = rd_data[VAR2_L +: VAR_W];
            n1_d = rd_data[NEG1_B];
            n2_d = rd_data[NEG2_B];
`endif
        end

        // Outputs are registered copies of what the next state presents.
        sv_d   = state_code(state_d);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            sv_q    <= SV_RST_CLAUSE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            v1_q    <= '0;
            v2_q    <= '0;
            n1_q    <= 1'b0;
            n2_q    <= 1'b0;
`ifdef SEQ_TAUTO_SKIP_EN
            skip_q   <= 1'b0;
            issued_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            sv_q    <= sv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
`ifdef SEQ_TAUTO_SKIP_EN
            skip_q   <= skip_d;
            issued_q <= issued_d;
`endif
        end
    end

    assign stateVal   = sv_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sat_result = sat_q;
    assign varPos1    = v1_q;
    assign varPos2    = v2_q;
    assign negCtrl1   = n1_q;
    assign negCtrl2   = n2_q;

endmodule

// File: tb/tb_sat_clause_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sat_clause_sequencer
// Self-checking bench: a trace-level model predicts, per cycle, the outputs
// of the sequencer from the clause list and run rules; a compare process
// checks every cycle after reset. Directed runs pin key literals (done
// cycle, phase sequence, literal fields), then randomized runs follow.
// ---------------------------------------------------------------------------
module tb_sat_clause_sequencer;

    localparam int MAX = 16;
    localparam int VW  = 5;
    localparam int LAT = 2;
    localparam int AW  = 4;
    localparam int RW  = 2 * VW + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;
    logic [AW:0]   num_clauses;
    logic          start;
    logic          busy;
    logic          done;
    logic          sat_result;
    logic [1:0]    stateVal;
    logic [VW-1:0] varPos1;
    logic [VW-1:0] varPos2;
    logic          negCtrl1;
    logic          negCtrl2;
    logic          outCNF;

    always #5 clk = ~clk;

    sat_clause_sequencer #(
        .MAX_CLAUSES (MAX),
        .VAR_W       (VW),
        .RESULT_LAT  (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .num_clauses (num_clauses),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .sat_result  (sat_result),
        .stateVal    (stateVal),
        .varPos1     (varPos1),
        .varPos2     (varPos2),
        .negCtrl1    (negCtrl1),
        .negCtrl2    (negCtrl2),
        .outCNF      (outCNF)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Trace model: one expected output record per cycle.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]    sv;
        logic          busy;
        logic          done;
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
        logic          n1;
        logic          n2;
        logic          sat;
    } exp_t;

    exp_t          cur;
    exp_t          trace[$];
    logic [RW-1:0] shadow [MAX];
    bit            model_ok = 1'b0;

    task automatic build_trace();
        exp_t e;
        int   k;
        int   issued;
        logic [RW-1:0] rec;
        k      = (int'(num_clauses) > MAX) ? MAX : int'(num_clauses);
        issued = 0;
        e      = cur;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.sv   = 2'b00;
        trace.push_back(e);
        for (int i = 0; i < k; i++) begin
            rec = shadow[i];
`ifdef SEQ_TAUTO_SKIP_EN
            if (rec[VW-1:0] == rec[2*VW:VW+1] && rec[VW] != rec[2*VW+1]) begin
                e.sv = 2'b01;
                trace.push_back(e);
                continue;
            end
`endif
            e.v1 = rec[VW-1:0];
            e.n1 = rec[VW];
            e.v2 = rec[2*VW:VW+1];
            e.n2 = rec[2*VW+1];
            e.sv = 2'b01; trace.push_back(e);
            e.sv = 2'b10; trace.push_back(e);
            e.sv = 2'b11; trace.push_back(e);
            issued++;
        end
        e.sv = 2'b01;
        for (int w = 0; w < LAT; w++) trace.push_back(e);
        e.done = 1'b1;
        e.sat  = (issued == 0) ? 1'b1 : outCNF;
        trace.push_back(e);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            cur      = '0;
            cur.sv   = 2'b01;
            trace.delete();
            model_ok = 1'b1;
        end else begin
            if (!cur.busy) begin
                if (wr_en) shadow[wr_addr] = wr_data;
                if (start) build_trace();
            end
            if (trace.size() > 0) begin
                cur = trace.pop_front();
            end else begin
                cur.sv   = 2'b01;
                cur.busy = 1'b0;
                cur.done = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        exp_t got;
        if (model_ok) begin
            got = {stateVal, busy, done, varPos1, varPos2, negCtrl1, negCtrl2, sat_result};
            checks++;
            if (got !== cur) begin
                errors++;
                $display("FAIL cycle @%0t: got sv=%b busy=%b done=%b v1=%0d v2=%0d n1=%b n2=%b sat=%b, expected sv=%b busy=%b done=%b v1=%0d v2=%0d n1=%b n2=%b sat=%b",
                         $time, got.sv, got.busy, got.done, got.v1, got.v2, got.n1, got.n2, got.sat,
                         cur.sv, cur.busy, cur.done, cur.v1, cur.v2, cur.n1, cur.n2, cur.sat);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] cl(input int v1, input bit n1, input int v2, input bit n2);
        return {n2, VW'(v2), n1, VW'(v1)};
    endfunction

    task automatic write_slot(input int addr, input logic [RW-1:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    logic [1:0]    sv_log [512];
    logic [VW-1:0] v1_log [512];
    logic [VW-1:0] v2_log [512];
    logic          n1_log [512];

    // Runs one formula; drel is the cycle (start edge = edge 0) with done.
    task automatic run(input int ncl, input bit oc, input bit disturb,
                       output int drel, output bit dsat);
        int rel;
        int extra;
        @(negedge clk);
        num_clauses = (AW + 1)'(ncl);
        outCNF      = oc;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rel   = 1;
        drel  = -1;
        dsat  = 1'b0;
        while (rel < 400) begin
            sv_log[rel] = stateVal;
            v1_log[rel] = varPos1;
            v2_log[rel] = varPos2;
            n1_log[rel] = negCtrl1;
            if (done) begin
                drel = rel;
                dsat = sat_result;
                break;
            end
            if (disturb && rel == 3) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = RW'($urandom);
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
            rel++;
        end
        checks++;
        if (drel < 0) begin
            errors++;
            $display("FAIL run-timeout: got no done, expected done within 400 cycles");
        end
        if (disturb) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = RW'($urandom);
        end
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (done) extra++;
        end
        check("done-once", 32'(extra), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [1:0] exp_sv [11];
    int         drel;
    bit         dsat;
    int         dcount;

    initial begin
        reset       = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        num_clauses = '0;
        start       = 1'b0;
        outCNF      = 1'b0;
        exp_sv[1] = 2'b00; exp_sv[2] = 2'b01; exp_sv[3] = 2'b10; exp_sv[4] = 2'b11;
        exp_sv[5] = 2'b01; exp_sv[6] = 2'b10; exp_sv[7] = 2'b11; exp_sv[8] = 2'b01;
        exp_sv[9] = 2'b01; exp_sv[10] = 2'b01;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        repeat (10) begin
            @(negedge clk);
            check("idle-after-reset", 32'({stateVal, busy, done, sat_result}), 32'b01000);
        end

        // Fill every slot with non-tautological clauses.
        for (int i = 0; i < MAX; i++) begin
            int v;
            v = int'($urandom_range(0, 31));
            write_slot(i, cl(v, 1'($urandom), v ^ 1, 1'($urandom)));
        end

        // Empty formula.
        run(0, 1'b0, 1'b0, drel, dsat);
        check("empty-done-cycle", 32'(drel), 32'd4);
        check("empty-sat", 32'(dsat), 32'd1);

        // (x1 | x2), (~x1 | x3), verdict 0.
        write_slot(0, cl(1, 1'b0, 2, 1'b0));
        write_slot(1, cl(1, 1'b1, 3, 1'b0));
        run(2, 1'b0, 1'b0, drel, dsat);
        check("two-clause-done-cycle", 32'(drel), 32'd10);
        if (drel == 10) begin
            for (int r = 1; r <= 10; r++) check($sformatf("phase-seq[%0d]", r), 32'(sv_log[r]), 32'(exp_sv[r]));
        end
        check("clause0-var1", 32'(v1_log[2]), 32'd1);
        check("clause0-var2", 32'(v2_log[2]), 32'd2);
        check("clause1-var1", 32'(v1_log[5]), 32'd1);
        check("clause1-var2", 32'(v2_log[5]), 32'd3);
        check("clause0-neg1", 32'(n1_log[3]), 32'd0);
        check("clause1-neg1", 32'(n1_log[6]), 32'd1);
        check("two-clause-sat0", 32'(dsat), 32'd0);

        // Verdict 1 with start/wr_en pokes while busy; verdict held afterwards.
        run(2, 1'b1, 1'b1, drel, dsat);
        check("disturbed-done-cycle", 32'(drel), 32'd10);
        check("disturbed-sat1", 32'(dsat), 32'd1);
        repeat (5) @(negedge clk);
        check("sat-held", 32'(sat_result), 32'd1);
        run(2, 1'b0, 1'b0, drel, dsat);
        check("slot0-unchanged-var1", 32'(v1_log[2]), 32'd1);
        check("slot0-unchanged-var2", 32'(v2_log[2]), 32'd2);

        // Clamp: 20 requested, 16 issued.
        run(20, 1'b1, 1'b0, drel, dsat);
        check("clamp-done-cycle", 32'(drel), 32'd52);

        // Reset during EVAL of the first clause.
        @(negedge clk);
        num_clauses = 5'd2;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset-eval", 32'(stateVal), 32'b10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post-reset-outputs", 32'({stateVal, busy, done, varPos1, negCtrl1, sat_result}), 32'({2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0}));
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no-done-after-reset", 32'(dcount), 32'd0);

        // Tautology followed by (x1 | x2).
        write_slot(0, cl(4, 1'b0, 4, 1'b1));
        write_slot(1, cl(1, 1'b0, 2, 1'b0));
        run(2, 1'b1, 1'b0, drel, dsat);
`ifdef SEQ_TAUTO_SKIP_EN
        check("tauto-done-cycle", 32'(drel), 32'd8);
`else
        check("tauto-done-cycle", 32'(drel), 32'd10);
`endif
        check("tauto-sat", 32'(dsat), 32'd1);

        // Randomized runs, checked cycle by cycle against the model.
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                int v;
                v = int'($urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0)
                    write_slot(int'($urandom_range(0, MAX - 1)), cl(v, 1'b0, v, 1'b1));
                else
                    write_slot(int'($urandom_range(0, MAX - 1)), RW'($urandom));
            end
            run(int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom), drel, dsat);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
